// File: rtl/match_record_reader_if.sv
// ---------------------------------------------------------------------------
// match_record_reader_if
//   Bundles the match-memory read port and the host-facing record stream.
//   master : the reader (drives mem_rd/mem_addr and the out_* stream)
//   slave  : memory + downstream sink (drives mem_rdata and out_ready)
//   Signals:
//     mem_rd, mem_addr  read strobe / address (reader -> memory)
//     mem_rdata         read data, one cycle after mem_rd (memory -> reader)
//     out_data, out_valid, out_sop, out_eop   stream word (reader -> host)
//     out_ready         host accepts word on out_valid & out_ready
// ---------------------------------------------------------------------------
interface match_record_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;

    modport master (
        output mem_rd, mem_addr, out_data, out_valid, out_sop, out_eop,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, out_data, out_valid, out_sop, out_eop,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/match_record_reader.sv
// ---------------------------------------------------------------------------
// match_record_reader
//   Drains matched-packet records from the match memory in write order and
//   streams them to the host, one word at a time, tagging each record with
//   sop/eop. The read pointer is exported so the writer can detect full.
//   Ports:
//     clk      system clock, rising edge
//     n_rst    asynchronous active-low reset
//     wr_addr  writer's next-write address (advances by whole records)
//     flush    drop all stored records (acted on in IDLE only)
//     rd_addr  next address to be read
//     busy     high whenever the FSM is not in IDLE
//     bus      memory read port + output stream (master modport)
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | wait for a stored record, or apply a flush
//   ISSUE     | drive mem_rd with mem_addr = rd_addr
//   WAIT_DATA | capture mem_rdata into the output register
//   PRESENT   | hold the word until the host accepts it
// ---------------------------------------------------------------------------
module match_record_reader #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 8,
    parameter int RECORD_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  flush,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  busy,
    match_record_reader_if.master bus
);
    localparam int CNT_W = $clog2(RECORD_WORDS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DATA = 2'd2;
    localparam logic [1:0] S_PRESENT   = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  word_cnt;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_sop_q;
    logic              out_eop_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            rd_addr     <= '0;
            word_cnt    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        rd_addr  <= wr_addr;
                        word_cnt <= '0;
                    end else if (rd_addr != wr_addr) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    out_data_q  <= bus.mem_rdata;
                    out_valid_q <= 1'b1;
                    out_sop_q   <= (word_cnt == '0);
                    out_eop_q   <= (word_cnt == CNT_W'(RECORD_WORDS - 1));
                    state       <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_sop_q   <= 1'b0;
                        out_eop_q   <= 1'b0;
                        rd_addr     <= rd_addr + 1'b1;
                        // RECORD_WORDS is a power of two, so the counter
                        // wraps back to the record boundary on its own.
                        word_cnt    <= word_cnt + 1'b1;
                        // Records are atomic: only the last word returns to
                        // IDLE, where wr_addr is looked at again.
                        state       <= out_eop_q ? S_IDLE : S_ISSUE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = (state == S_ISSUE);
    assign bus.mem_addr  = rd_addr;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_match_record_reader.sv
module tb_match_record_reader;
    typedef struct {
        int          cyc;
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } hs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic [7:0] wr_a, rd_a;
    logic       flush_a, busy_a;
    logic [2:0] wr_b, rd_b;
    logic       flush_b, busy_b;

    match_record_reader_if #(.DATA_W(32), .ADDR_W(8)) ifa ();
    match_record_reader_if #(.DATA_W(32), .ADDR_W(3)) ifb ();

    match_record_reader #(.DATA_W(32), .ADDR_W(8), .RECORD_WORDS(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .wr_addr(wr_a), .flush(flush_a),
        .rd_addr(rd_a), .busy(busy_a), .bus(ifa)
    );
    match_record_reader #(.DATA_W(32), .ADDR_W(3), .RECORD_WORDS(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .wr_addr(wr_b), .flush(flush_b),
        .rd_addr(rd_b), .busy(busy_b), .bus(ifb)
    );

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [8];

    // Memory models: data one cycle after the read strobe.
    always @(posedge clk) if (ifa.mem_rd) ifa.mem_rdata <= mem_a[ifa.mem_addr];
    always @(posedge clk) if (ifb.mem_rd) ifb.mem_rdata <= mem_b[ifb.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] rd_log_a[$];
    logic [2:0] rd_log_b[$];
    hs_t        hs_log_a[$];
    hs_t        hs_log_b[$];
    logic       prev_stall_a = 1'b0;
    logic [34:0] prev_word_a;

    // Log reads and accepted words; a stalled word must stay put.
    always @(negedge clk) begin
        #1;
        if (!n_rst) begin
            prev_stall_a = 1'b0;
        end else begin
            if (prev_stall_a)
                chk("stall_hold", 64'({ifa.out_valid, ifa.out_sop, ifa.out_eop, ifa.out_data}),
                    64'(prev_word_a));
            if (ifa.mem_rd) rd_log_a.push_back(ifa.mem_addr);
            if (ifa.out_valid && ifa.out_ready)
                hs_log_a.push_back('{cyc, ifa.out_sop, ifa.out_eop, ifa.out_data});
            if (ifb.mem_rd) rd_log_b.push_back(ifb.mem_addr);
            if (ifb.out_valid && ifb.out_ready)
                hs_log_b.push_back('{cyc, ifb.out_sop, ifb.out_eop, ifb.out_data});
            prev_stall_a = ifa.out_valid && !ifa.out_ready;
            prev_word_a  = {1'b1, ifa.out_sop, ifa.out_eop, ifa.out_data};
        end
    end

    task automatic clear_logs();
        rd_log_a.delete(); hs_log_a.delete();
        rd_log_b.delete(); hs_log_b.delete();
    endtask

    task automatic wait_hs_a(input int n);
        int k = 0;
        while (hs_log_a.size() < n && k < 600) begin @(negedge clk); k++; end
        chk("hs_timeout_a", 64'(hs_log_a.size() >= n), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    // Reference: n words from address start, record position = index mod 4.
    task automatic check_stream_a(input logic [7:0] start, input int n);
        chk("n_reads", 64'(rd_log_a.size()), 64'(n));
        chk("n_words", 64'(hs_log_a.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = start + 8'(i);
            if (i < rd_log_a.size()) chk("read_addr", 64'(rd_log_a[i]), 64'(a));
            if (i < hs_log_a.size()) begin
                chk("word_data", 64'(hs_log_a[i].data), 64'(mem_a[a]));
                chk("word_sop", 64'(hs_log_a[i].sop), 64'((i % 4) == 0));
                chk("word_eop", 64'(hs_log_a[i].eop), 64'((i % 4) == 3));
            end
        end
        chk("rd_addr_end", 64'(rd_a), 64'(8'(start + 8'(n))));
        chk("busy_end", 64'(busy_a), 64'(0));
    endtask

    task automatic accept_word(input int hold);
        int k = 0;
        logic [33:0] w;
        while (!ifa.out_valid && k < 50) begin @(negedge clk); k++; end
        chk("valid_seen", 64'(ifa.out_valid), 64'(1));
        w = {ifa.out_sop, ifa.out_eop, ifa.out_data};
        repeat (hold) begin
            @(negedge clk);
            chk("bp_hold", 64'({ifa.out_valid, ifa.mem_rd, ifa.out_sop, ifa.out_eop, ifa.out_data}),
                64'({2'b10, w}));
        end
        ifa.out_ready = 1'b1;
        @(negedge clk);
        ifa.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ptr;
        int nw, k;
        n_rst = 1'b0;
        wr_a = '0; flush_a = 1'b0; wr_b = '0; flush_b = 1'b0;
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem_a[i] = $urandom;
        for (int i = 0; i < 8; i++) mem_b[i] = $urandom;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 64'({ifa.out_valid, ifa.out_sop, ifa.out_eop, ifa.mem_rd, busy_a}), 64'(0));
        chk("rst_data", 64'(ifa.out_data), 64'(0));
        chk("rst_ptr", 64'({rd_a, ifa.mem_addr}), 64'(0));
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single record with latency check
        clear_logs();
        wr_a = 8'd4;
        @(negedge clk);
        chk("first_read", 64'({ifa.mem_rd, ifa.mem_addr}), 64'({1'b1, 8'd0}));
        wait_hs_a(4);
        check_stream_a(8'd0, 4);
        for (int i = 1; i < hs_log_a.size(); i++)
            chk("word_spacing", 64'(hs_log_a[i].cyc - hs_log_a[i-1].cyc), 64'(3));

        // Backpressure on word 2
        clear_logs();
        ifa.out_ready = 1'b0;
        wr_a = 8'd8;
        accept_word(0); accept_word(0); accept_word(10); accept_word(0);
        repeat (3) @(negedge clk);
        check_stream_a(8'd4, 4);

        // Flush in IDLE
        clear_logs();
        wr_a = 8'd16; flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("flush_ptr", 64'(rd_a), 64'(16));
        chk("flush_quiet", 64'({rd_log_a.size(), hs_log_a.size()}), 64'(0));
        chk("flush_busy", 64'(busy_a), 64'(0));

        // Flush during PRESENT is ignored
        clear_logs();
        wr_a = 8'd20;
        k = 0;
        while (!ifa.out_valid && k < 50) begin @(negedge clk); k++; end
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        ifa.out_ready = 1'b1;
        wait_hs_a(4);
        check_stream_a(8'd16, 4);

        // Two queued records, one IDLE cycle between them
        clear_logs();
        wr_a = 8'd28;
        wait_hs_a(8);
        check_stream_a(8'd20, 8);
        for (int i = 1; i < hs_log_a.size(); i++)
            chk("rec_spacing", 64'(hs_log_a[i].cyc - hs_log_a[i-1].cyc), 64'((i % 4 == 0) ? 4 : 3));

        // Random record counts with random backpressure
        ptr = 8'd28;
        for (int it = 0; it < 4; it++) begin
            nw = 4 * $urandom_range(1, 3);
            clear_logs();
            wr_a = ptr + 8'(nw);
            k = 0;
            while ((hs_log_a.size() < nw || busy_a) && k < 800) begin
                @(negedge clk);
                ifa.out_ready = 1'($urandom_range(0, 1));
                k++;
            end
            ifa.out_ready = 1'b1;
            repeat (2) @(negedge clk);
            check_stream_a(ptr, nw);
            ptr = ptr + 8'(nw);
        end

        // Reset mid-PRESENT
        ifa.out_ready = 1'b0;
        wr_a = ptr + 8'd4;
        k = 0;
        while (!ifa.out_valid && k < 50) begin @(negedge clk); k++; end
        chk("pre_rst_valid", 64'(ifa.out_valid), 64'(1));
        n_rst = 1'b0;
        #1;
        chk("rst_mid_out", 64'({ifa.out_valid, ifa.mem_rd, busy_a}), 64'(0));
        chk("rst_mid_ptr", 64'(rd_a), 64'(0));
        wr_a = 8'd0;
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
        clear_logs();
        ifa.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_idle", 64'({busy_a, rd_a}), 64'(0));
        chk("post_rst_reads", 64'(rd_log_a.size()), 64'(0));

        // Wrap on the 3-bit instance
        clear_logs();
        wr_b = 3'd4;
        k = 0;
        while (hs_log_b.size() < 4 && k < 100) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        chk("wrap_pre_ptr", 64'(rd_b), 64'(4));
        clear_logs();
        wr_b = 3'd0;
        k = 0;
        while (hs_log_b.size() < 4 && k < 100) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        chk("wrap_reads", 64'(rd_log_b.size()), 64'(4));
        chk("wrap_words", 64'(hs_log_b.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log_b.size()) chk("wrap_addr", 64'(rd_log_b[i]), 64'(4 + i));
            if (i < hs_log_b.size()) begin
                chk("wrap_data", 64'(hs_log_b[i].data), 64'(mem_b[4 + i]));
                chk("wrap_sopeop", 64'({hs_log_b[i].sop, hs_log_b[i].eop}),
                    64'({i == 0, i == 3}));
            end
        end
        chk("wrap_ptr", 64'({rd_b, busy_b}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
